mem_arbiter: RTL and testbench

Sequences and shares the single multi-cycle main data memory between the instruction-cache miss handler, the data-cache miss handler and the data-cache write-through path. It sits between both cache controllers and the memory instance. It turns each granted miss into a pipelined 8-word block fill, and each granted write into a single-cycle memory write. Only one transaction owns the memory at a time.

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle main memory between the I-cache miss
// handler, the D-cache miss handler and the D-cache write-through path.
// A granted miss becomes a pipelined block fill of WORDS reads; a granted
// write becomes a single-cycle memory write. One owner at a time, with a
// one-cycle turnaround so the served requester can drop its request.
module mem_arbiter #(
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       i_miss_req,
  input  logic [15:0]                i_miss_addr,
  output logic                       i_fill_valid,
  output logic [$clog2(WORDS)-1:0]   i_fill_word,
  output logic                       i_fill_done,

  input  logic                       d_miss_req,
  input  logic [15:0]                d_miss_addr,
  output logic                       d_fill_valid,
  output logic [$clog2(WORDS)-1:0]   d_fill_word,
  output logic                       d_fill_done,

  output logic [15:0]                fill_data,

  input  logic                       d_wr_req,
  input  logic [15:0]                d_wr_addr,
  input  logic [15:0]                d_wr_data,
  output logic                       d_wr_ack,

  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_data_out,
  output logic                       mem_enable,
  output logic                       mem_wr,
  input  logic [15:0]                mem_data_in,
  input  logic                       mem_data_valid,

  output logic                       busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

  // Reject configurations the block addressing cannot support.
  if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_params
    $error("mem_arbiter: WORDS must be a power of two >= 2 and MEM_LAT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FILL  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_W    = 2'd3
  } owner_t;

  state_t            state;
  owner_t            owner;
  logic [CNT_W-1:0]  iss;
  logic [CNT_W-1:0]  ret;

  // Request payload captured at grant time.
  logic [15:0]       req_addr_p0;
  logic [15:0]       wr_data_p0;

  logic              issuing;
  logic              take_ret;
  logic              last_ret;

  // Word address of read number idx inside the block that contains a.
  // The block is aligned to 2*WORDS bytes; the low byte bit is dropped.
  function automatic logic [15:0] fill_addr(input logic [15:0]      a,
                                            input logic [CNT_W-1:0] idx);
    logic [15:0] mask;
    mask      = 16'hFFFF << (IDX_W + 1);
    fill_addr = (a & mask) + (16'(idx) << 1);
  endfunction

  assign issuing  = (state == S_FILL) && (iss != CNT_FULL);
  assign take_ret = (state == S_FILL) && mem_data_valid && (ret != CNT_FULL);
  assign last_ret = take_ret && (ret == CNT_LAST);

  // Control FSM: arbitration, ownership and fill counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= OWN_NONE;
      iss   <= '0;
      ret   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          iss <= '0;
          ret <= '0;
          // Data side first: it is older in program order.
          if (d_wr_req) begin
            state <= S_WRITE;
            owner <= OWN_W;
          end else if (d_miss_req) begin
            state <= S_FILL;
            owner <= OWN_D;
          end else if (i_miss_req) begin
            state <= S_FILL;
            owner <= OWN_I;
          end
        end
        S_WRITE: begin
          state <= S_TURN;
        end
        S_FILL: begin
          if (issuing) begin
            iss <= iss + 1'b1;
          end
          if (take_ret) begin
            ret <= ret + 1'b1;
          end
          if (last_ret) begin
            state <= S_TURN;
          end
        end
        S_TURN: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
        default: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Payload capture in IDLE, same priority as the grant; data needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (d_wr_req) begin
        req_addr_p0 <= d_wr_addr;
        wr_data_p0  <= d_wr_data;
      end else if (d_miss_req) begin
        req_addr_p0 <= d_miss_addr;
      end else if (i_miss_req) begin
        req_addr_p0 <= i_miss_addr;
      end
    end
  end

  // Output decode from state, counters and captured payload only.
  always_comb begin
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    d_wr_ack     = 1'b0;
    fill_data    = '0;
    i_fill_valid = 1'b0;
    i_fill_word  = '0;
    i_fill_done  = 1'b0;
    d_fill_valid = 1'b0;
    d_fill_word  = '0;
    d_fill_done  = 1'b0;
    case (state)
      S_WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = req_addr_p0;
        mem_data_out = wr_data_p0;
        d_wr_ack     = 1'b1;
      end
      S_FILL: begin
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = fill_addr(req_addr_p0, iss);
        end
        if (take_ret) begin
          fill_data = mem_data_in;
          if (owner == OWN_I) begin
            i_fill_valid = 1'b1;
            i_fill_word  = ret[IDX_W-1:0];
            i_fill_done  = last_ret;
          end else if (owner == OWN_D) begin
            d_fill_valid = 1'b1;
            d_fill_word  = ret[IDX_W-1:0];
            d_fill_done  = last_ret;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: timeline reference model, memory model with
// fixed latency, directed vector table, hand-written corner sequences and
// randomized requester traffic.
module tb_mem_arbiter;

  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;
  localparam int NCYC    = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_req;
  logic [15:0] i_miss_addr;
  logic        i_fill_valid;
  logic [2:0]  i_fill_word;
  logic        i_fill_done;
  logic        d_miss_req;
  logic [15:0] d_miss_addr;
  logic        d_fill_valid;
  logic [2:0]  d_fill_word;
  logic        d_fill_done;
  logic [15:0] fill_data;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        d_wr_ack;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        busy;

  mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .i_fill_valid(i_fill_valid), .i_fill_word(i_fill_word), .i_fill_done(i_fill_done),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_fill_valid(d_fill_valid), .d_fill_word(d_fill_word), .d_fill_done(d_fill_done),
    .fill_data(fill_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        ack;
    logic        iv;
    logic [2:0]  iw;
    logic        idn;
    logic        dv;
    logic [2:0]  dw;
    logic        ddn;
    logic [15:0] fd;
    logic        busy;
  } obs_t;

  typedef struct packed {
    int          due;
    logic [15:0] addr;
  } rd_t;

  typedef struct packed {
    logic [1:0]  kind;      // 0 I-miss, 1 D-miss, 2 write
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_addr;  // first memory address after grant
    logic [7:0]  exp_off;   // grant to done/ack distance
  } vec_t;

  obs_t exp_q [NCYC];
  obs_t obs   [NCYC];
  bit   infill[NCYC];
  rd_t  rdq[$];

  int cyc, free_at, i_drop, d_drop, w_drop;
  int tests, fails;
  bit stray_en;

  // Memory contents: any fixed function of the address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_future(input int from);
    for (int c = from; c < NCYC; c++) begin
      exp_q[c]  = '0;
      infill[c] = 1'b0;
    end
  endtask

  // Timeline model: a grant at cycle g fixes every later output event.
  task automatic model_grant();
    int          g, dn, r;
    bit          dside;
    logic [15:0] base, a;
    g = cyc;
    if (d_wr_req) begin
      exp_q[g+1].en   = 1'b1;
      exp_q[g+1].wr   = 1'b1;
      exp_q[g+1].addr = d_wr_addr;
      exp_q[g+1].dout = d_wr_data;
      exp_q[g+1].ack  = 1'b1;
      exp_q[g+1].busy = 1'b1;
      exp_q[g+2].busy = 1'b1;
      w_drop  = g + 2;
      free_at = g + 3;
    end else begin
      dside = d_miss_req;
      base  = (dside ? d_miss_addr : i_miss_addr) & ~16'(2 * WORDS - 1);
      dn    = g + WORDS + MEM_LAT;
      for (int j = 0; j < WORDS; j++) begin
        a = base + 16'(2 * j);
        exp_q[g+1+j].en   = 1'b1;
        exp_q[g+1+j].addr = a;
        r = g + 1 + MEM_LAT + j;
        exp_q[r].fd = memf(a);
        if (dside) begin
          exp_q[r].dv  = 1'b1;
          exp_q[r].dw  = 3'(j);
          exp_q[r].ddn = (j == WORDS - 1);
        end else begin
          exp_q[r].iv  = 1'b1;
          exp_q[r].iw  = 3'(j);
          exp_q[r].idn = (j == WORDS - 1);
        end
      end
      for (int c = g + 1; c <= dn + 1; c++) exp_q[c].busy = 1'b1;
      for (int c = g + 1; c <= dn; c++) infill[c] = 1'b1;
      if (dside) d_drop = dn + 1;
      else       i_drop = dn + 1;
      free_at = dn + 2;
    end
  endtask

  // One clock cycle: requester drops, memory return, model, compare.
  task automatic step();
    obs_t e;
    rd_t  rd;
    if (i_drop == cyc) begin i_miss_req = 1'b0; i_drop = -1; end
    if (d_drop == cyc) begin d_miss_req = 1'b0; d_drop = -1; end
    if (w_drop == cyc) begin d_wr_req   = 1'b0; w_drop = -1; end
    if (rdq.size() > 0 && rdq[0].due <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data_in    = memf(rdq[0].addr);
      void'(rdq.pop_front());
    end else if (stray_en && !infill[cyc] && $urandom_range(4) == 0) begin
      mem_data_valid = 1'b1;
      mem_data_in    = 16'($urandom);
    end else begin
      mem_data_valid = 1'b0;
      mem_data_in    = 16'($urandom);
    end
    if (rst) begin
      clear_future(cyc + 1);
      free_at = cyc + 1;
      i_drop = -1; d_drop = -1; w_drop = -1;
    end else if (cyc >= free_at && (d_wr_req || d_miss_req || i_miss_req)) begin
      model_grant();
    end
    @(negedge clk);
    obs[cyc].en   = mem_enable;     obs[cyc].wr   = mem_wr;
    obs[cyc].addr = mem_addr;       obs[cyc].dout = mem_data_out;
    obs[cyc].ack  = d_wr_ack;
    obs[cyc].iv   = i_fill_valid;   obs[cyc].iw   = i_fill_word;  obs[cyc].idn = i_fill_done;
    obs[cyc].dv   = d_fill_valid;   obs[cyc].dw   = d_fill_word;  obs[cyc].ddn = d_fill_done;
    obs[cyc].fd   = fill_data;      obs[cyc].busy = busy;
    if (!rst) begin
      e = exp_q[cyc];
      check("mem_ctl", 64'({mem_enable, mem_wr}), 64'({e.en, e.wr}));
      if (e.en) check("mem_addr", 64'(mem_addr), 64'(e.addr));
      if (e.wr) check("mem_wdata", 64'(mem_data_out), 64'(e.dout));
      check("wr_ack", 64'(d_wr_ack), 64'(e.ack));
      check("i_fill_vd", 64'({i_fill_valid, i_fill_done}), 64'({e.iv, e.idn}));
      if (e.iv) check("i_fill_word", 64'(i_fill_word), 64'(e.iw));
      check("d_fill_vd", 64'({d_fill_valid, d_fill_done}), 64'({e.dv, e.ddn}));
      if (e.dv) check("d_fill_word", 64'(d_fill_word), 64'(e.dw));
      if (e.iv || e.dv) check("fill_data", 64'(fill_data), 64'(e.fd));
      check("busy", 64'(busy), 64'(e.busy));
    end
    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      rd.due  = cyc + MEM_LAT;
      rd.addr = mem_addr;
      rdq.push_back(rd);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_quiet();
    while ((cyc < free_at || i_miss_req || d_miss_req || d_wr_req) && cyc < NCYC - 40)
      step();
  endtask

  initial begin
    #((NCYC + 200) * 10);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "tb_mem_arbiter timeout");
  end

  initial begin
    vec_t vecs[6];
    int   k, off, cnt, ddone, idone, ifirst, ackc;

    rst = 1'b1;
    i_miss_req = 1'b0; i_miss_addr = '0;
    d_miss_req = 1'b0; d_miss_addr = '0;
    d_wr_req = 1'b0;   d_wr_addr = '0;   d_wr_data = '0;
    mem_data_in = '0;  mem_data_valid = 1'b0;
    cyc = 0; free_at = 0; i_drop = -1; d_drop = -1; w_drop = -1;
    tests = 0; fails = 0; stray_en = 1'b0;
    clear_future(0);

    step();
    step();
    rst = 1'b0;
    stray_en = 1'b1;
    step();
    check("reset_outputs", 64'(obs[cyc-1]), 64'(0));

    // Directed single transactions from IDLE, issued back to back.
    vecs[0] = '{2'd0, 16'h1236, 16'h0000, 16'h1230, 8'd12};
    vecs[1] = '{2'd1, 16'h0000, 16'h0000, 16'h0000, 8'd12};
    vecs[2] = '{2'd1, 16'hFFF8, 16'h0000, 16'hFFF0, 8'd12};
    vecs[3] = '{2'd2, 16'h0040, 16'hBEEF, 16'h0040, 8'd1};
    vecs[4] = '{2'd0, 16'h000F, 16'h0000, 16'h0000, 8'd12};
    vecs[5] = '{2'd2, 16'hFFFE, 16'h1234, 16'hFFFE, 8'd1};
    for (int v = 0; v < 6; v++) begin
      k = cyc;
      case (vecs[v].kind)
        2'd0:    begin i_miss_req = 1'b1; i_miss_addr = vecs[v].addr; end
        2'd1:    begin d_miss_req = 1'b1; d_miss_addr = vecs[v].addr; end
        default: begin d_wr_req = 1'b1; d_wr_addr = vecs[v].addr; d_wr_data = vecs[v].data; end
      endcase
      step();
      run_quiet();
      check("vec_first_addr", 64'(obs[k+1].addr), 64'(vecs[v].exp_addr));
      off = -1;
      for (int c = k; c < cyc; c++) begin
        if (off < 0 && (obs[c].idn || obs[c].ddn || obs[c].ack)) off = c - k;
      end
      check("vec_done_off", 64'(off), 64'(vecs[v].exp_off));
      if (vecs[v].kind == 2'd2) check("vec_wdata", 64'(obs[k+1].dout), 64'(vecs[v].data));
    end

    // I and D miss in the same cycle: D first, I reads start at D-done+3.
    k = cyc;
    i_miss_req = 1'b1; i_miss_addr = 16'h2000;
    d_miss_req = 1'b1; d_miss_addr = 16'h3004;
    step();
    run_quiet();
    ddone = -1; idone = -1; ifirst = -1;
    for (int c = k; c < cyc; c++) begin
      if (ddone < 0 && obs[c].ddn) ddone = c;
      if (idone < 0 && obs[c].idn) idone = c;
    end
    for (int c = k; c < cyc; c++)
      if (ifirst < 0 && c > ddone && obs[c].en && !obs[c].wr && obs[c].addr == 16'h2000) ifirst = c;
    check("dual_d_done", 64'(ddone - k), 64'(12));
    check("dual_i_first", 64'(ifirst - ddone), 64'(3));
    check("dual_i_done", 64'(idone - ddone), 64'(14));

    // Write raised during an I fill waits for the fill to finish.
    k = cyc;
    i_miss_req = 1'b1; i_miss_addr = 16'h4452;
    step(); step(); step();
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    run_quiet();
    cnt = 0; ackc = -1;
    for (int c = k; c <= k + 14; c++) if (obs[c].wr) cnt++;
    for (int c = k; c < cyc; c++) if (ackc < 0 && obs[c].ack) ackc = c;
    check("wdf_no_early_wr", 64'(cnt), 64'(0));
    check("wdf_ack_cycle", 64'(ackc - k), 64'(15));
    check("wdf_cmd", 64'({obs[ackc].en, obs[ackc].wr, obs[ackc].addr, obs[ackc].dout}),
          64'({1'b1, 1'b1, 16'h0040, 16'hBEEF}));

    // Write and D miss together: write acked at k+1, fill issues from k+4.
    k = cyc;
    d_wr_req = 1'b1; d_wr_addr = 16'h1111; d_wr_data = 16'h2222;
    d_miss_req = 1'b1; d_miss_addr = 16'h5678;
    step();
    run_quiet();
    check("wd_ack", 64'(obs[k+1].ack), 64'(1));
    check("wd_gap", 64'({obs[k+2].en, obs[k+3].en}), 64'(0));
    check("wd_fill_start", 64'({obs[k+4].en, obs[k+4].wr, obs[k+4].addr}), 64'({1'b1, 1'b0, 16'h5670}));

    // Reset at grant+6 of an I fill with returns still in flight.
    k = cyc;
    i_miss_req = 1'b1; i_miss_addr = 16'h1236;
    for (int n = 0; n < 6; n++) step();
    rst = 1'b1; i_miss_req = 1'b0;
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) step();
    check("rst_outputs_zero", 64'(obs[k+7]), 64'(0));
    cnt = 0;
    for (int c = k; c < cyc; c++) if (obs[c].idn) cnt++;
    check("rst_no_done", 64'(cnt), 64'(0));
    cnt = 0;
    for (int c = k + 7; c < cyc; c++) if (obs[c].iv || obs[c].busy) cnt++;
    check("rst_stray_ignored", 64'(cnt), 64'(0));
    k = cyc;
    i_miss_req = 1'b1; i_miss_addr = 16'h1236;
    step();
    run_quiet();
    off = -1;
    for (int c = k; c < cyc; c++) if (off < 0 && obs[c].idn) off = c - k;
    check("rst_refill_done", 64'(off), 64'(12));

    // Random requester traffic against the timeline model.
    for (int n = 0; n < 2500 && cyc < NCYC - 40; n++) begin
      if (!i_miss_req && $urandom_range(7) == 0) begin
        i_miss_req = 1'b1; i_miss_addr = 16'($urandom);
      end
      if (!d_miss_req && $urandom_range(7) == 0) begin
        d_miss_req = 1'b1; d_miss_addr = 16'($urandom);
      end
      if (!d_wr_req && $urandom_range(9) == 0) begin
        d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
      step();
    end
    run_quiet();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
